// File: rtl/phy_serdes_lane.sv
// phy_serdes_lane: single-lane serialiser/deserialiser on one bit clock.
// TX sends one DATA_W word MSB first every DATA_W cycles. It sends COM_SYM when no word
// can be sent. RX bit-aligns on COM_SYM and reports ACTIVE after SYNC_COUNT consecutive
// aligned COMs. Words offered while the link is down come back on recirc/valid_r.
module phy_serdes_lane #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] COM_SYM    = DATA_W'(8'hBC),
  parameter int                SYNC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              loopback_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic              serial_out,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic [DATA_W-1:0] recirc,
  output logic              valid_r
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [3:0]        SYNC_TGT = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGNED = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_t;

  logic [CNT_W-1:0]  tx_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] tx_sel;

  rx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_nxt;
  logic [3:0]        com_cnt, com_cnt_nxt;
  logic [DATA_W-1:0] rx_sh, rx_sh_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_out_nxt;
  logic              lb_q;
  logic              rx_bit;
  logic [DATA_W-1:0] rx_word;
  logic              rx_boundary;
  logic              rx_is_com;

  assign ready_in = reset_L && (tx_cnt == '0);
  assign active   = (state == ACTIVE);

  // Word to load at a word boundary: real data only once the link is up
  always_comb begin
    tx_sel = (valid_in && active) ? data_in : COM_SYM;
  end

  // TX word counter, MSB-first shifter, and the refusal path for words offered while down
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      tx_cnt     <= '0;
      tx_sh      <= '0;
      serial_out <= 1'b0;
      recirc     <= '0;
      valid_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      tx_cnt  <= (tx_cnt == LAST_BIT) ? '0 : tx_cnt + 1'b1;
      if (tx_cnt == '0) begin
        serial_out <= tx_sel[DATA_W-1];
        tx_sh      <= {tx_sel[DATA_W-2:0], 1'b0};
        if (valid_in && !active) begin
          recirc  <= data_in;
          valid_r <= 1'b1;
        end
      end else begin
        serial_out <= tx_sh[DATA_W-1];
        tx_sh      <= {tx_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  // RX next-state: alignment search, COM counting, data capture, loopback-change restart
  always_comb begin
    rx_bit        = loopback_en ? serial_out : serial_in;
    rx_word       = {rx_sh[DATA_W-2:0], rx_bit};
    rx_boundary   = (rx_cnt == LAST_BIT);
    rx_is_com     = (rx_word == COM_SYM);
    state_nxt     = state;
    rx_cnt_nxt    = rx_cnt;
    com_cnt_nxt   = com_cnt;
    rx_sh_nxt     = rx_word;
    data_nxt      = data_out;
    valid_out_nxt = 1'b0;
    if (loopback_en != lb_q) begin
      state_nxt   = SEARCH;
      com_cnt_nxt = '0;
      rx_sh_nxt   = '0;
      rx_cnt_nxt  = '0;
    end else begin
      case (state)
        SEARCH: begin
          if (rx_is_com) begin
            state_nxt   = (SYNC_COUNT == 1) ? ACTIVE : ALIGNED;
            rx_cnt_nxt  = '0;
            com_cnt_nxt = 4'd1;
          end
        end
        ALIGNED: begin
          rx_cnt_nxt = rx_boundary ? '0 : rx_cnt + 1'b1;
          if (rx_boundary) begin
            if (rx_is_com) begin
              com_cnt_nxt = (com_cnt == SYNC_TGT) ? com_cnt : com_cnt + 4'd1;
              if (com_cnt + 4'd1 >= SYNC_TGT) begin
                state_nxt = ACTIVE;
              end
            end else begin
              state_nxt   = SEARCH;
              com_cnt_nxt = '0;
            end
          end
        end
        ACTIVE: begin
          rx_cnt_nxt = rx_boundary ? '0 : rx_cnt + 1'b1;
          if (rx_boundary && !rx_is_com) begin
            data_nxt      = rx_word;
            valid_out_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt   = SEARCH;
          com_cnt_nxt = '0;
          rx_cnt_nxt  = '0;
        end
      endcase
    end
  end

  // RX state register; lb_q follows loopback_en in reset so release is not seen as a change
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state     <= SEARCH;
      rx_cnt    <= '0;
      com_cnt   <= '0;
      rx_sh     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lb_q      <= loopback_en;
    end else begin
      state     <= state_nxt;
      rx_cnt    <= rx_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      rx_sh     <= rx_sh_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_out_nxt;
      lb_q      <= loopback_en;
    end
  end

endmodule
